// File: rtl/seq_shift_pkg.sv
// seq_shift_pkg
//   Shared definitions for the sequential right shifter: the FSM state
//   encoding and the default operand / shift-amount widths.
package seq_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_NIO = 8;  // operand / result width
  localparam int DEF_SAW = 3;  // shift-amount width

endpackage : seq_shift_pkg

// File: rtl/seq_shift_right.sv
// seq_shift_right
//   Multi-cycle right shifter. Shifts an NIO-bit operand right by SH
//   positions, one position per clock, with sign fill (ARITH=1) or zero
//   fill (ARITH=0). Companion to the ALU's combinational shift-left.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request, sampled only while idle
//   A          operand, captured on an accepted start
//   SH         shift amount 0..2^SAW-1, captured on an accepted start
//   ARITH      1 = arithmetic (sign fill), 0 = logical (zero fill)
//   Z          result, registered, held until the next result loads
//   OV         inexact flag: some shifted-out bit was 1; held with Z
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse while in the DONE state
//   dbg_state  current FSM state encoding
//
// Handshake: a start is accepted on a rising edge where start=1 and
// busy=0. Exactly one done pulse follows SH+1 cycles later (1 cycle for
// SH=0). Any start seen while busy=1, including the DONE cycle, is
// dropped, not queued. Z/OV change only on the edge entering DONE.
//
// Parameter constraint: NIO >= 2^SAW, so the largest shift never
// consumes the whole operand.
module seq_shift_right
  import seq_shift_pkg::*;
#(
  parameter int NIO = DEF_NIO,
  parameter int SAW = DEF_SAW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [NIO-1:0] A,
  input  logic [SAW-1:0] SH,
  input  logic           ARITH,
  output logic [NIO-1:0] Z,
  output logic           OV,
  output logic           busy,
  output logic           done,
  output logic [1:0]     dbg_state
);

  state_e         state_q,  state_d;
  logic [NIO-1:0] acc_q,    acc_d;
  logic [SAW-1:0] cnt_q,    cnt_d;
  logic           fill_q,   fill_d;
  logic           sticky_q, sticky_d;
  logic [NIO-1:0] z_q,      z_d;
  logic           ov_q,     ov_d;

  // One-position shift of the working value and the sticky bit that
  // would result from it; used both for the running update and for the
  // final load into Z/OV so the last shift is included in the result.
  logic [NIO-1:0] acc_shift;
  logic           sticky_shift;

  assign acc_shift    = {fill_q, acc_q[NIO-1:1]};
  assign sticky_shift = sticky_q | acc_q[0];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    sticky_d = sticky_q;
    z_d      = z_q;
    ov_d     = ov_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = A;
          cnt_d    = SH;
          fill_d   = ARITH & A[NIO-1];
          sticky_d = 1'b0;
          if (SH == '0) begin
            // Nothing to shift: result is the operand itself, exact.
            state_d = ST_DONE;
            z_d     = A;
            ov_d    = 1'b0;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        acc_d    = acc_shift;
        sticky_d = sticky_shift;
        cnt_d    = cnt_q - SAW'(1);
        if (cnt_q == SAW'(1)) begin
          state_d = ST_DONE;
          z_d     = acc_shift;
          ov_d    = sticky_shift;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      fill_q   <= 1'b0;
      sticky_q <= 1'b0;
      z_q      <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      sticky_q <= sticky_d;
      z_q      <= z_d;
      ov_q     <= ov_d;
    end
  end

  // Status outputs decode the state register only, never start.
  assign Z         = z_q;
  assign OV        = ov_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule : seq_shift_right
